comp_seq: RTL and testbench



---
 rtl/comp_seq.sv | 116 +++++++++++
 tb/tb_comp_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_seq.sv
// comp_seq: digit-serial magnitude comparator.
// Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, and stops
// at the first differing digit. Signed operands are mapped to offset binary
// by flipping the MSB, so the scan itself is always an unsigned compare.
// Handshake: start (sampled in IDLE) -> busy through SCAN/DONE -> done pulse.
module comp_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] msb_mask;
  logic [DIGIT-1:0] sa_top;
  logic [DIGIT-1:0] sb_top;
  logic             last_digit;

  // MSB flip applied at load time when comparing two's-complement operands
  assign msb_mask   = {signed_mode, {(WIDTH-1){1'b0}}};
  assign sa_top     = sa[WIDTH-1 -: DIGIT];
  assign sb_top     = sb[WIDTH-1 -: DIGIT];
  assign last_digit = (cnt == CW'(NDIG - 1));

  // Control FSM, operand shift registers, digit counter and registered flags
  // NOTE: every register here (including the operand shift registers) is
  // cleared by the async reset so an aborted scan leaves no stale state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      eq    <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // reads the pre-edge values of sa/sb/cnt regardless of statement order.
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a ^ msb_mask;
            sb    <= b ^ msb_mask;
            cnt   <= '0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end

        SCAN: begin
          if (sa_top != sb_top) begin
            // First differing digit decides the result
            gt    <= (sa_top > sb_top);
            lt    <= (sa_top < sb_top);
            eq    <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (last_digit) begin
            eq    <= 1'b1;
            gt    <= 1'b0;
            lt    <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            sa  <= sa << DIGIT;
            sb  <= sb << DIGIT;
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comp_seq.sv
// tb_comp_seq: directed and randomized checks of comp_seq.
// One WIDTH=8/DIGIT=2 instance for directed tests, and three WIDTH=16
// instances (DIGIT = 1, 4, 16) driven in parallel for the random sweep.
module tb_comp_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // 8-bit instance signals
  logic       start8 = 1'b0;
  logic       sm8    = 1'b0;
  logic [7:0] a8     = '0;
  logic [7:0] b8     = '0;
  logic       busy8, done8, eq8, gt8, lt8;

  // 16-bit instance signals (shared inputs)
  logic        start16 = 1'b0;
  logic        sm16    = 1'b0;
  logic [15:0] a16     = '0;
  logic [15:0] b16     = '0;
  logic        busy16 [3];
  logic        done16 [3];
  logic        eq16   [3];
  logic        gt16   [3];
  logic        lt16   [3];

  int dg [3] = '{1, 4, 16};

  int checks = 0;
  int errors = 0;

  comp_seq #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .eq(eq8), .gt(gt8), .lt(lt8)
  );

  comp_seq #(.WIDTH(16), .DIGIT(1)) dut16_d1 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16[0]), .done(done16[0]),
    .eq(eq16[0]), .gt(gt16[0]), .lt(lt16[0])
  );

  comp_seq #(.WIDTH(16), .DIGIT(4)) dut16_d4 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16[1]), .done(done16[1]),
    .eq(eq16[1]), .gt(gt16[1]), .lt(lt16[1])
  );

  comp_seq #(.WIDTH(16), .DIGIT(16)) dut16_d16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16[2]), .done(done16[2]),
    .eq(eq16[2]), .gt(gt16[2]), .lt(lt16[2])
  );

  localparam logic [2:0] F_EQ = 3'b100;
  localparam logic [2:0] F_GT = 3'b010;
  localparam logic [2:0] F_LT = 3'b001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer compare for the flags, digit walk for the latency
  function automatic void model(input int w, input int d, input logic [15:0] a,
                                input logic [15:0] b, input logic sm,
                                output logic [2:0] fl, output int n);
    int  ia, ib, ua, ub, sh, m;
    bit  found;
    ua = int'(a);
    ub = int'(b);
    ia = ua;
    ib = ub;
    if (sm) begin
      if (ia >= (1 << (w - 1))) ia = ia - (1 << w);
      if (ib >= (1 << (w - 1))) ib = ib - (1 << w);
    end
    fl = (ia == ib) ? F_EQ : ((ia > ib) ? F_GT : F_LT);
    n = w / d;
    found = 1'b0;
    m = (1 << d) - 1;
    for (int i = 0; i < w / d; i++) begin
      sh = w - d * (i + 1);
      if (!found && (((ua >> sh) & m) != ((ub >> sh) & m))) begin
        n = i + 1;
        found = 1'b1;
      end
    end
  endfunction

  // One full transaction on the 8-bit instance, entered/left at posedge+1
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      input logic [2:0] exp_fl, input int exp_n, input string tag);
    int n;
    a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check({tag, " busy_after_accept"}, 32'(busy8), 32'd1);
    check({tag, " flags_cleared"}, 32'({eq8, gt8, lt8}), 32'd0);
    n = 0;
    while (!done8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_n));
    check({tag, " flags"}, 32'({eq8, gt8, lt8}), 32'(exp_fl));
    check({tag, " busy_in_done"}, 32'(busy8), 32'd1);
    @(posedge clk); #1;
    check({tag, " done_pulse_end"}, 32'({done8, busy8}), 32'd0);
    check({tag, " flags_held"}, 32'({eq8, gt8, lt8}), 32'(exp_fl));
  endtask

  // One random pair on all three 16-bit instances in parallel
  task automatic run16();
    bit         seen [3];
    int         n_got [3];
    logic [2:0] fl_got [3];
    logic [2:0] fl_exp;
    int         n_exp;
    int         c;
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    // Bias toward long common prefixes so late-digit and equal cases occur
    case ($urandom_range(3))
      0: b16 = a16;
      1: b16 = {a16[15:4], b16[3:0]};
      default: ;
    endcase
    sm16 = 1'($urandom);
    for (int k = 0; k < 3; k++) begin
      seen[k] = 1'b0; n_got[k] = 0; fl_got[k] = 3'b000;
    end
    start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    c = 0;
    while (!(seen[0] && seen[1] && seen[2]) && c < 24) begin
      @(posedge clk); #1;
      c++;
      for (int k = 0; k < 3; k++) begin
        if (!seen[k] && done16[k]) begin
          seen[k]   = 1'b1;
          n_got[k]  = c;
          fl_got[k] = {eq16[k], gt16[k], lt16[k]};
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      model(16, dg[k], a16, b16, sm16, fl_exp, n_exp);
      check($sformatf("w16d%0d a=%h b=%h s=%0d flags", dg[k], a16, b16, sm16),
            32'(fl_got[k]), 32'(fl_exp));
      check($sformatf("w16d%0d a=%h b=%h s=%0d latency", dg[k], a16, b16, sm16),
            32'(n_got[k]), 32'(n_exp));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] fl_exp;
    int         n_exp;
    int         n;
    logic [7:0] ra, rb;
    logic       rs;

    // Reset state
    #2;
    check("reset dut8 outputs", 32'({busy8, done8, eq8, gt8, lt8}), 32'd0);
    check("reset dut16 outputs", 32'({busy16[0], busy16[1], busy16[2],
                                       done16[0], done16[1], done16[2]}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle after reset", 32'({busy8, done8}), 32'd0);

    // Directed cases with hand-derived expectations
    run8(8'h1C, 8'h14, 1'b0, F_GT, 3, "uns_gt");
    run8(8'h1C, 8'h1C, 1'b0, F_EQ, 4, "equal");
    run8(8'h04, 8'h14, 1'b0, F_LT, 2, "uns_lt");
    run8(8'h9C, 8'h14, 1'b0, F_GT, 1, "uns_msb");
    run8(8'h9C, 8'h14, 1'b1, F_LT, 1, "sgn_neg");
    run8(8'hDC, 8'hD4, 1'b1, F_GT, 3, "sgn_both_neg");
    run8(8'h80, 8'h7F, 1'b1, F_LT, 1, "sgn_extremes");
    run8(8'h00, 8'h01, 1'b0, F_LT, 4, "last_digit");

    // Handshake: start held every cycle with changing operands
    a8 = 8'h7C; b8 = 8'h14; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    check("hs accept busy", 32'(busy8), 32'd1);
    a8 = 8'h01; b8 = 8'h01; sm8 = 1'b1;
    @(posedge clk); #1;
    check("hs first done", 32'(done8), 32'd1);
    check("hs first flags", 32'({eq8, gt8, lt8}), 32'(F_GT));
    a8 = 8'hFF; b8 = 8'h00;
    @(posedge clk); #1;
    check("hs start ignored in done", 32'({done8, busy8}), 32'd0);
    check("hs flags held", 32'({eq8, gt8, lt8}), 32'(F_GT));
    a8 = 8'h04; b8 = 8'h14; sm8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("hs back2back accept", 32'(busy8), 32'd1);
    check("hs back2back cleared", 32'({eq8, gt8, lt8}), 32'd0);
    n = 0;
    while (!done8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("hs back2back latency", 32'(n), 32'd2);
    check("hs back2back flags", 32'({eq8, gt8, lt8}), 32'(F_LT));
    @(posedge clk); #1;

    // Random 8-bit pairs against the model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = (i % 4 == 0) ? ra : 8'($urandom);
      rs = 1'($urandom);
      model(8, 2, {8'h00, ra}, {8'h00, rb}, rs, fl_exp, n_exp);
      run8(ra, rb, rs, fl_exp, n_exp, $sformatf("rnd8 a=%h b=%h s=%0d", ra, rb, rs));
    end

    // Reset mid-scan aborts the compare
    a8 = 8'h1C; b8 = 8'h1C; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midscan async reset outputs", 32'({busy8, done8, eq8, gt8, lt8}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midscan no done in reset", 32'(done8), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("midscan no done after release", 32'({done8, busy8}), 32'd0);
    end

    // Parameter sweep on the 16-bit instances
    for (int i = 0; i < 1000; i++) run16();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
